// File: rtl/usb_in_tx_sched_if.sv
// Host transmit channel shared by the IN scheduler and the packet serializer.
// The scheduler is the master; the serializer applies backpressure via tx_ready.
interface usb_in_tx_sched_if;
  logic        tx_valid;
  logic [3:0]  tx_pid;
  logic [7:0]  tx_data;
  logic [15:0] tx_len;
  logic        tx_last;
  logic        tx_ready;

  modport master (output tx_valid, tx_pid, tx_data, tx_len, tx_last, input tx_ready);
  modport slave  (input tx_valid, tx_pid, tx_data, tx_len, tx_last, output tx_ready);
endinterface

// File: rtl/usb_in_tx_sched.sv
// IN transaction scheduler: answers IN tokens with DATA0/DATA1, NAK or STALL
// and tracks each endpoint's data toggle through the host ACK.
module usb_in_tx_sched #(
  parameter int NUM_EP      = 4,
  parameter int MAX_PKT     = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            dev_addr,
  input  logic                  tok_valid,
  input  logic [3:0]            tok_pid,
  input  logic [6:0]            tok_addr,
  input  logic [3:0]            tok_ep,
  input  logic [NUM_EP-1:0]     ep_stall,
  input  logic [4*NUM_EP-1:0]   ep_level,
  input  logic [8*NUM_EP-1:0]   ep_rd_data,
  output logic [NUM_EP-1:0]     ep_rd_en,
  input  logic [NUM_EP-1:0]     toggle_clr,
  usb_in_tx_sched_if.master     tx,
  output logic                  busy,
  output logic [2:0]            dbg_state,
  output logic [NUM_EP-1:0]     dbg_toggle
);

  localparam int EW   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int LW   = $clog2(MAX_PKT + 1);
  localparam int CMAX = (MAX_PKT > ACK_TIMEOUT) ? MAX_PKT : ACK_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR      = 3'd1,
    DATA     = 3'd2,
    WAIT_ACK = 3'd3,
    HSK      = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [EW-1:0]     ep_q, ep_d;
  logic [LW-1:0]     len_q, len_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        pid_q, pid_d;
  logic [NUM_EP-1:0] toggle_q, toggle_d;

  logic [EW-1:0] tok_idx;
  logic [3:0]    tok_lvl;
  logic [LW-1:0] tok_len;
  logic          tok_tog;
  logic          accept;
  logic          data_last;

  always_comb begin
    state_d   = state_q;
    ep_d      = ep_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    pid_d     = pid_q;
    toggle_d  = toggle_q;
    ep_rd_en  = '0;
    tx.tx_valid = 1'b0;
    tx.tx_pid   = 4'h0;
    tx.tx_data  = 8'h00;
    tx.tx_len   = 16'h0000;
    tx.tx_last  = 1'b0;

    tok_idx   = EW'(tok_ep);
    tok_lvl   = ep_level[4*int'(tok_idx) +: 4];
    tok_len   = (32'(tok_lvl) > MAX_PKT) ? LW'(MAX_PKT) : LW'(tok_lvl);
    // A clear landing on the accept cycle must already apply to this packet.
    tok_tog   = toggle_q[tok_idx] & ~toggle_clr[tok_idx];
    accept    = tok_valid && (tok_pid == PID_IN) && (tok_addr == dev_addr)
                && (32'(tok_ep) < NUM_EP);
    data_last = (32'(cnt_q) + 1) == 32'(len_q);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ep_d  = tok_idx;
          len_d = tok_len;
          cnt_d = '0;
          if (ep_stall[tok_idx]) begin
            pid_d   = PID_STALL;
            state_d = HSK;
          end else if ((tok_len == '0) && (tok_idx != '0)) begin
            pid_d   = PID_NAK;
            state_d = HSK;
          end else begin
            pid_d   = tok_tog ? PID_DATA1 : PID_DATA0;
            state_d = HDR;
          end
        end
      end
      HDR: begin
        tx.tx_valid = 1'b1;
        tx.tx_pid   = pid_q;
        tx.tx_len   = 16'(len_q);
        tx.tx_last  = (len_q == '0);
        if (tx.tx_ready) begin
          cnt_d   = '0;
          state_d = (len_q == '0) ? WAIT_ACK : DATA;
        end
      end
      DATA: begin
        tx.tx_valid = 1'b1;
        tx.tx_pid   = pid_q;
        tx.tx_data  = ep_rd_data[8*int'(ep_q) +: 8];
        tx.tx_len   = 16'(len_q);
        tx.tx_last  = data_last;
        if (tx.tx_ready) begin
          ep_rd_en[ep_q] = 1'b1;
          if (data_last) begin
            cnt_d   = '0;
            state_d = WAIT_ACK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WAIT_ACK: begin
        // Any token ends the wait; only an ACK advances the toggle.
        if (tok_valid) begin
          if (tok_pid == PID_ACK) toggle_d[ep_q] = ~toggle_q[ep_q];
          state_d = IDLE;
        end else if (32'(cnt_q) == ACK_TIMEOUT - 1) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HSK: begin
        tx.tx_valid = 1'b1;
        tx.tx_pid   = pid_q;
        tx.tx_last  = 1'b1;
        if (tx.tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    toggle_d = toggle_d & ~toggle_clr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ep_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      pid_q    <= 4'h0;
      toggle_q <= '0;
    end else begin
      state_q  <= state_d;
      ep_q     <= ep_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      pid_q    <= pid_d;
      toggle_q <= toggle_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;
  assign dbg_toggle = toggle_q;

endmodule
